// File: rtl/demux_rr_ctrl.sv
// demux_rr_ctrl: round-robin 1-to-4 demultiplexer controller.
// A word is accepted in IDLE, a channel is chosen in ARB, and the word is
// presented on that channel in SEND until the channel signals ready.
// Optional feature macro: DEMUX_SKIP_EN. When it is defined, ARB skips
// channels that are not ready. When it is undefined, channels are used in
// strict rotation.
module demux_rr_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic [3:0] out_ready,
  output logic [3:0] out_valid,
  output logic [7:0] out_data,
  output logic [1:0] sel,
  output logic       busy,
  output logic [7:0] xfer_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  out_data_q, out_data_d;
  logic [7:0]  xfer_cnt_q, xfer_cnt_d;
  logic [3:0]  out_valid_q, out_valid_d;
  logic        busy_q, busy_d;

`ifdef DEMUX_SKIP_EN
  logic        found;
  logic [1:0]  cand;
`endif

  // One-hot decode of a channel index.
  function automatic logic [3:0] onehot(input logic [1:0] idx);
    logic [3:0] v;
    v = 4'b0000;
    v[idx] = 1'b1;
    return v;
  endfunction

  // A word can only be taken while idle; en gates the next accept only.
  assign in_ready = en && (state_q == IDLE);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sel       = sel_q;
  assign busy      = busy_q;
  assign xfer_cnt  = xfer_cnt_q;

  // Next-state and next-output computation for the controller.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    out_data_d  = out_data_q;
    xfer_cnt_d  = xfer_cnt_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
`ifdef DEMUX_SKIP_EN
    found       = 1'b0;
    cand        = 2'd0;
`endif
    case (state_q)
      IDLE: begin
        out_valid_d = 4'b0000;
        if (en && in_valid) begin
          out_data_d = in_data;
          state_d    = ARB;
          busy_d     = 1'b1;
        end
      end
      ARB: begin
`ifdef DEMUX_SKIP_EN
        // Work-conserving search starting at ptr; the first ready channel wins.
        for (int i = 0; i < 4; i++) begin
          cand = ptr_q + 2'(i);
          if (!found && out_ready[cand]) begin
            found = 1'b1;
            sel_d = cand;
          end
        end
        if (found) begin
          state_d     = SEND;
          out_valid_d = onehot(sel_d);
        end
`else
        // Strict rotation: the pointed-to channel is always chosen.
        sel_d       = ptr_q;
        state_d     = SEND;
        out_valid_d = onehot(ptr_q);
`endif
      end
      SEND: begin
        // Only the selected channel's ready matters; the others are ignored.
        if (out_ready[sel_q]) begin
          state_d     = IDLE;
          ptr_d       = sel_q + 2'd1;
          xfer_cnt_d  = xfer_cnt_q + 8'd1;
          out_valid_d = 4'b0000;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 4'b0000;
        busy_d      = 1'b0;
      end
    endcase
  end

  // Controller registers; reset discards any held word without counting it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      sel_q       <= 2'd0;
      out_data_q  <= 8'h00;
      xfer_cnt_q  <= 8'h00;
      out_valid_q <= 4'b0000;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      out_data_q  <= out_data_d;
      xfer_cnt_q  <= xfer_cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: doc/demux_rr_ctrl.md
DEMUX_RR_CTRL -- requirements
Module: demux_rr_ctrl

Interface
REQ-001 SHALL have ports: clk input 1 (rising-edge clock); rst input 1 (asynchronous, active-high reset); en input 1 (accept enable); in_valid input 1 (source word present); in_data input 8 (source word); in_ready output 1 (controller accepts word); out_ready input 4 (per-channel sink ready); out_valid output 4 (one-hot channel strobe); out_data output 8 (held word, shared by all channels); sel output 2 (current demux select); busy output 1 (state != IDLE); xfer_cnt output 8 (completed deliveries, wraps).
REQ-002 SHALL use one clock (clk); reset rst SHALL be asynchronous and active-high.

Function
REQ-003 SHALL implement FSM states IDLE, ARB, SEND, all registered.
REQ-004 IDLE: in_ready = en; on in_valid & in_ready, SHALL latch in_data into out_data and go to ARB next cycle; otherwise remain in IDLE.
REQ-005 in_ready SHALL be 0 in ARB and SEND, regardless of en.
REQ-006 ARB: SHALL choose the channel per REQ-013/REQ-014, load sel, and go to SEND; if no channel is eligible, SHALL stay in ARB with sel unchanged.
REQ-007 SEND: out_valid SHALL equal the one-hot decode of sel; all other out_valid bits SHALL be 0; out_valid SHALL be all-zero in IDLE and ARB.
REQ-008 SEND: on out_ready[sel]=1, SHALL go to IDLE, set ptr = sel+1 mod 4 (3 wraps to 0), and increment xfer_cnt by 1 (255 wraps to 0); otherwise hold, keeping out_data and sel stable.
REQ-009 Minimum latency: accept at edge N, out_valid at N+2, IDLE at N+3 if out_ready is already high; peak throughput 1 word per 3 cycles.
REQ-010 en deasserted during ARB or SEND SHALL NOT abort the in-flight word; it only blocks the next accept.
REQ-011 out_ready bits of non-selected channels SHALL be ignored in SEND.
REQ-012 ptr (2-bit, internal) SHALL advance only on a completed delivery.

Reset
REQ-015 rst=1 SHALL immediately force: state IDLE, ptr 0, sel 0, out_data 8'h00, xfer_cnt 0, out_valid 4'b0000, busy 0.
REQ-016 rst asserted mid-ARB or mid-SEND SHALL discard the held word without counting it; the first accept after release SHALL target the arbitration starting at channel 0.

Configuration
REQ-013 With DEMUX_SKIP_EN defined: ARB SHALL choose the first channel c, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4), with out_ready[c]=1 in that cycle (work-conserving round-robin).
REQ-014 Without DEMUX_SKIP_EN: ARB SHALL always choose c = ptr and proceed to SEND immediately (strict rotation); SEND waits for out_ready[ptr]; no channel is skipped.

Verification
REQ-017 Reset, then en=1, in_valid=1, in_data=8'hA5, out_ready=4'hF -> out_valid 0001 two cycles after accept, out_data=A5, xfer_cnt=1, sel=0.
REQ-018 Four back-to-back words 11,22,33,44 with out_ready=4'hF -> delivered on channels 0,1,2,3 in order, each 3 cycles apart; the fifth word goes to channel 0.
REQ-019 DEMUX_SKIP_EN defined, ptr=1, out_ready=4'b1001 -> sel=3, out_valid=1000; next ptr=0.
REQ-020 DEMUX_SKIP_EN undefined, ptr=1, out_ready=4'b0000 for 5 cycles then 4'b0010 -> out_valid=0010 held all 6 cycles, delivery on the 6th, xfer_cnt+1.
REQ-021 en=0 with in_valid=1 -> in_ready=0, no state change; rst pulse during SEND with word 8'h5A -> out_valid=0 at once, xfer_cnt unchanged, ptr=0.
REQ-022 256 deliveries -> xfer_cnt wraps to 0.
